// File: rtl/mem_access_ctrl.sv
// Request/response initiator for the 16x16 register memory: serialises writes, dual reads and clears.
// Read responses arrive READ_LAT+2 cycles after acceptance; write, clear and illegal responses arrive 2 cycles after acceptance.
module mem_access_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [2:0]        mem_opcode,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out1,
  input  logic [DATA_W-1:0] mem_data_out2
);

  localparam int CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {IDLE, READ, WRITE, CLEAR, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  data1_q, data1_d, data2_q, data2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      wdata_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      wdata_q <= wdata_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    wdata_d = wdata_q;
    data1_d = data1_q;
    data2_d = data2_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr1_d = req_addr1;
          addr2_d = req_addr2;
          wdata_d = req_wdata;
          data1_d = '0;
          data2_d = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          case (req_op)
            2'b00:   state_d = READ;
            2'b01:   state_d = WRITE;
            2'b10:   state_d = CLEAR;
            // Illegal ops burn the CLEAR slot with the opcode gated off, so all
            // non-read responses share the same two-cycle latency.
            default: begin
              state_d = CLEAR;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      READ: begin
        if (cnt_q == CNT_W'(READ_LAT)) begin
          data1_d = mem_data_out1;
          data2_d = mem_data_out2;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE:   state_d = RESP;
      CLEAR:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_err     = (state_q == RESP) && err_q;
  assign rsp_data1   = data1_q;
  assign rsp_data2   = data2_q;
  assign mem_we      = (state_q == WRITE);
  assign mem_opcode  = ((state_q == CLEAR) && !err_q) ? 3'b110 : 3'b000;
  assign mem_addr1   = addr1_q;
  assign mem_addr2   = addr2_q;
  assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 16x16 memory (registered reads, latency 1).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [3:0]  req_addr1 = '0;
  logic [3:0]  req_addr2 = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data1, rsp_data2;
  logic        rsp_err;
  logic        mem_we;
  logic [2:0]  mem_opcode;
  logic [3:0]  mem_addr1, mem_addr2;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out1, mem_data_out2;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [16];

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_opcode(mem_opcode),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_data_in(mem_data_in),
    .mem_data_out1(mem_data_out1), .mem_data_out2(mem_data_out2)
  );

  initial for (int i = 0; i < 16; i++) mem[i] = 16'h1111 * i[15:0] + 16'h0101;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr1] <= mem_data_in;
    else if (mem_opcode == 3'b110) for (int i = 0; i < 16; i++) mem[i] <= '0;
    mem_data_out1 <= mem[mem_addr1];
    mem_data_out2 <= mem[mem_addr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency and memory-side pulses, optionally
  // hold off rsp_ready for `hold` cycles, then retire the response.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [3:0] a1,
                        input logic [3:0] a2, input logic [15:0] wd, input int exp_lat,
                        input logic exp_err, input logic [15:0] exp_d1,
                        input logic [15:0] exp_d2, input int exp_we, input int exp_opc,
                        input int hold);
    int lat, we_n, opc_n, waited;
    logic [3:0] wa;
    logic [15:0] wdat;
    lat = 0; we_n = 0; opc_n = 0; waited = 0; wa = '0; wdat = '0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr1 = a1; req_addr2 = a2; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin
        we_n++; wa = mem_addr1; wdat = mem_data_in;
      end
      if (mem_opcode == 3'b110) opc_n++;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, "_data1"}, {16'd0, rsp_data1}, {16'd0, exp_d1});
    chk({tag, "_data2"}, {16'd0, rsp_data2}, {16'd0, exp_d2});
    chk({tag, "_we_pulses"}, we_n, exp_we);
    chk({tag, "_clr_pulses"}, opc_n, exp_opc);
    if (exp_we > 0) begin
      chk({tag, "_wr_addr"}, {28'd0, wa}, {28'd0, a1});
      chk({tag, "_wr_data"}, {16'd0, wdat}, {16'd0, wd});
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_hold_data1"}, {16'd0, rsp_data1}, {16'd0, exp_d1});
      chk({tag, "_hold_data2"}, {16'd0, rsp_data2}, {16'd0, exp_d2});
      chk({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_hold_we"}, {31'd0, mem_we}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, "_retired_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_retired_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_opcode", {29'd0, mem_opcode}, 32'd0);
    chk("reset_addr1", {28'd0, mem_addr1}, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req("wr3",   2'b01, 4'd3, 4'd0, 16'hBEEF, 2, 1'b0, 16'h0000, 16'h0000, 1, 0, 0);
    do_req("wr9",   2'b01, 4'd9, 4'd0, 16'h1234, 2, 1'b0, 16'h0000, 16'h0000, 1, 0, 0);
    do_req("rd39",  2'b00, 4'd3, 4'd9, 16'h0000, 3, 1'b0, 16'hBEEF, 16'h1234, 0, 0, 0);
    do_req("rd_a2", 2'b00, 4'd2, 4'd7, 16'h0000, 3, 1'b0, 16'h2323, 16'h7878, 0, 0, 0);
    do_req("clr",   2'b10, 4'd0, 4'd0, 16'h0000, 2, 1'b0, 16'h0000, 16'h0000, 0, 1, 0);
    do_req("rdclr", 2'b00, 4'd3, 4'd9, 16'h0000, 3, 1'b0, 16'h0000, 16'h0000, 0, 0, 0);
    do_req("wr5",   2'b01, 4'd5, 4'd0, 16'hA5A5, 2, 1'b0, 16'h0000, 16'h0000, 1, 0, 0);
    do_req("bp_rd", 2'b00, 4'd5, 4'd3, 16'h0000, 3, 1'b0, 16'hA5A5, 16'h0000, 0, 0, 5);
    do_req("ill",   2'b11, 4'd6, 4'd1, 16'hFFFF, 2, 1'b1, 16'h0000, 16'h0000, 0, 0, 0);
    do_req("rd_ill", 2'b00, 4'd6, 4'd5, 16'h0000, 3, 1'b0, 16'h0000, 16'hA5A5, 0, 0, 0);

    // Reset in the middle of a read: the response must never appear.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr1 = 4'd5; req_addr2 = 4'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    do_req("rd_after_rst", 2'b00, 4'd5, 4'd3, 16'h0000, 3, 1'b0, 16'hA5A5, 16'h0000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
